usart_rx_fifo: RTL and testbench
================================

Name: usart_rx_fifo

Overview:
- Parametrised successor to the fixed 8N1 USART receiver.
- Configurable frame format: data bits, parity, stop bits. Configurable baud divider.
- Received words are buffered in an internal first-word-fall-through FIFO, with sticky error flags.
- Sits between the board RX pin and any consumer logic (LED display, command parser) in the single clk domain.

Parameters:
- CLK_DIV, 10: clk cycles per bit period. Must be >=4. Example: 27 MHz / 115200 -> 234.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 8: FIFO word count. Power of two, >=2.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Asynchronous, active-low.
- usart_rxp, in, 1: serial line, idles high. Asynchronous to clk.
- rd_en, in, 1: pop the head word. Ignored when empty.
- rd_data, out, DATA_BITS: head-of-FIFO word. Valid whenever empty=0.
- empty, out, 1: FIFO empty.
- full, out, 1: FIFO full.
- count, out, $clog2(FIFO_DEPTH)+1: words held.
- err_clr, in, 1: clears all sticky error flags.
- frame_err, out, 1: sticky. A stop bit was sampled low.
- parity_err, out, 1: sticky. Parity mismatch.
- overrun, out, 1: sticky. A good word was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - FSM = IDLE; FIFO pointers = 0.
  - rd_data = 0, empty = 1, full = 0, count = 0.
  - All error flags = 0.
  - Synchroniser flops = 1.
- Input path: usart_rxp passes through a 2-flop synchroniser before any use.
- Bit counter: divider counter runs 0..CLK_DIV-1. The sample point is at count CLK_DIV/2 (integer division).
- FSM states:
  - IDLE: a falling edge on the synchronised line -> START. Divider cleared.
  - START: at the sample point, line low -> DATA with the bit index cleared. Line high -> IDLE (glitch reject, nothing recorded).
  - DATA: sample one bit per bit period into a shift register, LSB first. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: sample one bit.
    - Odd mode: XOR of data and parity bit must be 1.
    - Even mode: XOR must be 0.
    - Result latched -> STOP.
  - STOP: sample STOP_BITS stop bits. On the first low stop bit: frame_err <= 1, word discarded -> BREAK. All stop bits high -> commit -> IDLE.
  - BREAK: wait for the synchronised line high -> IDLE. Holds off a long break so it cannot retrigger start.
- Commit rules, evaluated on the cycle of the final stop-bit sample:
  - Parity bad: parity_err <= 1, word discarded.
  - Otherwise, FIFO not full or rd_en=1 on the same cycle: word written.
  - Otherwise: overrun <= 1, word discarded. Existing contents are untouched.
- Latency: the word appears at rd_data/empty=0 on the clock edge after the final stop-bit sample.
  - Applies when the FIFO was empty.
  - Measured from the falling edge of the start bit, the total is (1 + DATA_BITS + parity bit + STOP_BITS - 0.5) x CLK_DIV + 3 clks. The 3 clks are the synchroniser plus the write.
- FIFO:
  - FWFT organisation; rd_en pops the head on the clock edge.
  - Simultaneous write and pop: count unchanged. Allowed even when full.
  - Pop while empty: ignored, with no underflow flag.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- Errors:
  - err_clr clears all three flags.
  - err_clr coinciding with a new error event: the set wins.
  - Errors never stop reception.
- Reset mid-frame: reset aborts immediately; the partial word is lost. After release, the FSM waits in IDLE for a fresh falling edge. A line held low at release does not start a frame.

Optional Feature:
- Macro: USART_RX_MAJORITY_EN.
- Defined: each start, data, parity and stop sample is a 2-of-3 majority of synchronised samples at divider counts CLK_DIV/2-1, CLK_DIV/2 and CLK_DIV/2+1. The decision is made at CLK_DIV/2+1, so latency grows by 1 clk.
- Undefined: a single sample at CLK_DIV/2. No vote logic is synthesised.

Test Plan:
- Back-to-back frames, defaults (CLK_DIV=10, 8N1): send 55, AA, 12, 34, 55, AA with rd_en held low -> count = 6, empty = 0, no error flags. Popping returns 55, AA, 12, 34, 55, AA in order.
- Overrun, FIFO_DEPTH=4: send 9 bytes 01..09 with no reads -> full = 1, overrun = 1. Reads return 01, 02, 03, 04. After err_clr, overrun = 0.
- Parity, PARITY=2, DATA_BITS=7:
  - Send 0x41 with parity 0 -> accepted.
  - Send 0x43 with parity 0 -> parity_err = 1, count stays 1.
- Framing, STOP_BITS=2: send A5 with the second stop bit low, then the line high for 3 bit periods, then 5A -> frame_err = 1. Only 5A is in the FIFO.
- Glitch and reset:
  - A 3-clk low pulse on the idle line -> no word, no error.
  - rst_n asserted mid-data of byte C3, then released, then 3C sent -> FIFO holds only 3C.
- With USART_RX_MAJORITY_EN: a 1-clk inverted spike at the sample point of data bit 3 of 0x00 -> 0x00 is received. Without the macro, the same stimulus yields 0x08.

Source files
------------

// File: rtl/usart_rx_fifo.sv
// Parametrised USART receiver (data bits, parity, stop bits, baud divider) feeding a FWFT FIFO
// with sticky error flags. Define USART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module usart_rx_fifo #(
    parameter int CLK_DIV    = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          usart_rxp,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          err_clr,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] SAMP_PT   = DIV_W'(CLK_DIV / 2);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [1:0]             sync_vld_q;
    logic                   rx_prev_q;
    logic                   rx_s, fall;
    logic [DIV_W-1:0]       div_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_bad_q;
    logic                   samp_en, samp_bit;
    logic                   shift_en, idx_clr, idx_inc, par_load, commit, frame_set;
    logic                   wr_en, pop, par_set, ovr_set;
    logic [ADDR_W:0]        wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    // The edge detector only trusts the line once real samples have flushed the
    // synchroniser, so a line held low across reset release never looks like a start bit.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            sync_vld_q <= 2'b00;
            rx_prev_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], usart_rxp};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_prev_q  <= rx_s & sync_vld_q[1];
        end
    end

    assign rx_s = sync_q[1];
    assign fall = rx_prev_q & ~rx_s;

`ifdef USART_RX_MAJORITY_EN
    localparam logic [DIV_W-1:0] VOTE_A = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] VOTE_C = DIV_W'(CLK_DIV / 2 + 1);
    logic [1:0] vote_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 2'b00;
        end else begin
            if (div_q == VOTE_A) vote_q[0] <= rx_s;
            if (div_q == SAMP_PT) vote_q[1] <= rx_s;
        end
    end

    assign samp_en  = (div_q == VOTE_C);
    assign samp_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign samp_en  = (div_q == SAMP_PT);
    assign samp_bit = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        par_load  = 1'b0;
        commit    = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (samp_en) begin
                    if (!samp_bit) begin
                        state_d = ST_DATA;
                        idx_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (samp_en) begin
                    shift_en = 1'b1;
                    if (idx_q == DATA_LAST) begin
                        idx_clr = 1'b1;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (samp_en) begin
                    par_load = 1'b1;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (samp_en) begin
                    if (!samp_bit) begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end else if (idx_q == STOP_LAST) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The cycle the fall is seen counts as divider 0, so the divider resumes at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) div_q <= fall ? DIV_W'(1) : '0;
            else if (div_q == DIV_LAST) div_q <= '0;
            else div_q <= div_q + DIV_W'(1);

            if (idx_clr)      idx_q <= '0;
            else if (idx_inc) idx_q <= idx_q + IDX_W'(1);

            if (shift_en) shreg_q <= {samp_bit, shreg_q[DATA_BITS-1:1]};

            if (state_q == ST_START)
                par_bad_q <= 1'b0;
            else if (par_load)
                par_bad_q <= (PARITY == 1) ? ~(^shreg_q ^ samp_bit) : (^shreg_q ^ samp_bit);
        end
    end

    // A full FIFO still accepts the word when the consumer pops on the same edge.
    assign pop     = rd_en & ~empty;
    assign wr_en   = commit & ~par_bad_q & (~full | rd_en);
    assign par_set = commit & par_bad_q;
    assign ovr_set = commit & ~par_bad_q & full & ~rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_set | (frame_err  & ~err_clr);
            parity_err <= par_set   | (parity_err & ~err_clr);
            overrun    <= ovr_set   | (overrun    & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
        end
    end

    // NOTE: storage has no reset; rd_data is forced to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= shreg_q;
    end

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign rd_data = empty ? '0 : mem[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Scoreboard bench for usart_rx_fifo: three instances (8N1 depth 8, 7E1 depth 4, 8N2 depth 4)
// driven by a frame generator; a reference model decides each frame's fate from the frame rules.
module tb_usart_rx_fifo;

    localparam int CLK_DIV = 10;
    localparam int HALF    = CLK_DIV / 2;
`ifdef USART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rxp    [3];
    logic       rd_en  [3];
    logic       err_clr[3];
    logic       empty  [3];
    logic       full   [3];
    logic       fe     [3];
    logic       pe     [3];
    logic       ov     [3];
    logic [8:0] rdd    [3];
    logic [3:0] cnt    [3];

    logic [7:0] rd_a, rd_c;
    logic [6:0] rd_b;
    logic [3:0] cnt_a;
    logic [2:0] cnt_b, cnt_c;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] q0[$], q1[$], q2[$];
    bit exp_fe[3], exp_pe[3], exp_ov[3];

    usart_rx_fifo #(.CLK_DIV(CLK_DIV)) u_a (
        .clk(clk), .rst_n(rst_n), .usart_rxp(rxp[0]), .rd_en(rd_en[0]), .rd_data(rd_a),
        .empty(empty[0]), .full(full[0]), .count(cnt_a), .err_clr(err_clr[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0])
    );

    usart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .usart_rxp(rxp[1]), .rd_en(rd_en[1]), .rd_data(rd_b),
        .empty(empty[1]), .full(full[1]), .count(cnt_b), .err_clr(err_clr[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1])
    );

    usart_rx_fifo #(.CLK_DIV(CLK_DIV), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .usart_rxp(rxp[2]), .rd_en(rd_en[2]), .rd_data(rd_c),
        .empty(empty[2]), .full(full[2]), .count(cnt_c), .err_clr(err_clr[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2])
    );

    always_comb begin
        rdd[0] = {1'b0, rd_a};
        rdd[1] = {2'b0, rd_b};
        rdd[2] = {1'b0, rd_c};
        cnt[0] = cnt_a;
        cnt[1] = {1'b0, cnt_b};
        cnt[2] = {1'b0, cnt_c};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Frame format of each instance
    function automatic int db(input int i);  return (i == 1) ? 7 : 8; endfunction
    function automatic int par(input int i); return (i == 1) ? 2 : 0; endfunction
    function automatic int sb(input int i);  return (i == 2) ? 2 : 1; endfunction
    function automatic int dep(input int i); return (i == 0) ? 8 : 4; endfunction

    function automatic int q_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void q_push(input int i, input logic [8:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic logic [8:0] q_pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_status(input int i, input string tag);
        string p;
        p = $sformatf("%s[%0d]", tag, i);
        check({p, "_count"},      cnt[i],   q_size(i));
        check({p, "_empty"},      empty[i], q_size(i) == 0);
        check({p, "_full"},       full[i],  q_size(i) == dep(i));
        check({p, "_frame_err"},  fe[i],    exp_fe[i]);
        check({p, "_parity_err"}, pe[i],    exp_pe[i]);
        check({p, "_overrun"},    ov[i],    exp_ov[i]);
    endtask

    // Monitor: every pop the DUT accepts is compared against the scoreboard head.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && rd_en[i] && !empty[i]) begin
                if (q_size(i) == 0) check($sformatf("spurious_word[%0d]", i), rdd[i], 9'h100);
                else check($sformatf("rd_data[%0d]", i), rdd[i], q_pop(i));
            end
        end
    end

    function automatic logic par_bit(input int i, input logic [8:0] d);
        logic x;
        x = 1'b0;
        for (int j = 0; j < db(i); j++) x ^= d[j];
        return (par(i) == 1) ? ~x : x;
    endfunction

    // Drives one frame LSB first. spike_k inverts that frame bit for one clk at its centre;
    // abort_at stops driving before that bit and leaves the model untouched.
    task automatic send_frame(input int i, input logic [8:0] d, input bit par_flip,
                              input logic [1:0] stop_v, input int spike_k, input int abort_at);
        logic [15:0] fr, eff;
        logic [8:0]  data;
        int          nb, pos;
        bit          pok, sok;
        fr = '0;
        nb = 1;
        for (int j = 0; j < db(i); j++) begin fr[nb] = d[j]; nb++; end
        if (par(i) != 0) begin fr[nb] = par_bit(i, d) ^ par_flip; nb++; end
        for (int j = 0; j < sb(i); j++) begin fr[nb] = stop_v[j]; nb++; end
        @(posedge clk); #1;
        for (int k = 0; k < nb; k++) begin
            if (k == abort_at) return;
            for (int c = 0; c < CLK_DIV; c++) begin
                rxp[i] = (k == spike_k && c == HALF) ? ~fr[k] : fr[k];
                @(posedge clk); #1;
            end
        end
        rxp[i] = 1'b1;
        // Reference: what the receiver should conclude about this frame.
        eff = fr;
        if (spike_k >= 0 && MAJ == 0) eff[spike_k] = ~eff[spike_k];
        data = '0;
        for (int j = 0; j < db(i); j++) data[j] = eff[1 + j];
        pos = 1 + db(i);
        pok = 1'b1;
        if (par(i) != 0) begin
            pok = ((^data) ^ eff[pos]) == (par(i) == 1);
            pos++;
        end
        sok = 1'b1;
        for (int j = 0; j < sb(i); j++) if (!eff[pos + j]) sok = 1'b0;
        if (!sok)                   exp_fe[i] = 1'b1;
        else if (!pok)              exp_pe[i] = 1'b1;
        else if (q_size(i) < dep(i)) q_push(i, data);
        else                        exp_ov[i] = 1'b1;
    endtask

    task automatic pop_all(input int i);
        int g;
        g = 0;
        while (!empty[i] && g < 32) begin
            rd_en[i] = 1'b1;
            @(posedge clk); #1;
            rd_en[i] = 1'b0;
            @(posedge clk); #1;
            g++;
        end
        check($sformatf("drain_left[%0d]", i), q_size(i), 0);
    endtask

    task automatic clear_errors(input int i);
        err_clr[i] = 1'b1;
        @(posedge clk); #1;
        err_clr[i] = 1'b0;
        exp_fe[i] = 1'b0;
        exp_pe[i] = 1'b0;
        exp_ov[i] = 1'b0;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) begin
            exp_fe[i] = 1'b0; exp_pe[i] = 1'b0; exp_ov[i] = 1'b0;
        end
    endtask

    initial begin
        int n, lat;
        bit seen;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin rxp[i] = 1'b1; rd_en[i] = 1'b0; err_clr[i] = 1'b0; end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_status(i, "reset");
            check($sformatf("reset_rd_data[%0d]", i), rdd[i], 0);
        end

        // Back-to-back frames on 8N1; the first one also measures fall-to-word latency.
        fork
            send_frame(0, 9'h55, 1'b0, 2'b11, -1, -1);
            begin
                lat  = 0;
                seen = 1'b0;
                @(posedge clk);
                while (!seen && lat < 300) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (!empty[0]) seen = 1'b1;
                end
                check("latency", lat, (1 + 8 + 0 + 1) * CLK_DIV - HALF + 3 + MAJ);
            end
        join
        send_frame(0, 9'hAA, 1'b0, 2'b11, -1, -1);
        send_frame(0, 9'h12, 1'b0, 2'b11, -1, -1);
        send_frame(0, 9'h34, 1'b0, 2'b11, -1, -1);
        send_frame(0, 9'h55, 1'b0, 2'b11, -1, -1);
        send_frame(0, 9'hAA, 1'b0, 2'b11, -1, -1);
        check_status(0, "b2b");
        pop_all(0);

        // 3-clk glitch on the idle line must be rejected silently.
        rxp[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxp[0] = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_status(0, "glitch");

        // One-clk spike at the centre of data bit 3 of 0x00.
        send_frame(0, 9'h00, 1'b0, 2'b11, 4, -1);
        check_status(0, "spike");
        pop_all(0);

        // Randomised batches, occasionally overfilling the FIFO.
        for (int b = 0; b < 3; b++) begin
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                send_frame(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11, -1, -1);
                repeat ($urandom_range(0, 15)) @(posedge clk);
                #1;
            end
            check_status(0, "random");
            pop_all(0);
            clear_errors(0);
            check_status(0, "random_clr");
        end

        // Even parity, 7 data bits.
        send_frame(1, 9'h41, 1'b0, 2'b11, -1, -1);
        send_frame(1, 9'h43, 1'b1, 2'b11, -1, -1);
        check_status(1, "parity");
        clear_errors(1);
        check_status(1, "parity_clr");
        pop_all(1);
        for (int k = 0; k < 4; k++)
            send_frame(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b11, -1, -1);
        check_status(1, "parity_rand");
        pop_all(1);
        clear_errors(1);

        // Overrun on the depth-4, two-stop-bit instance.
        for (int k = 1; k <= 9; k++) send_frame(2, 9'(k), 1'b0, 2'b11, -1, -1);
        check_status(2, "overrun");
        pop_all(2);
        clear_errors(2);
        check_status(2, "overrun_clr");

        // Second stop bit low, line idle 3 bit periods, then a good frame.
        send_frame(2, 9'hA5, 1'b0, 2'b01, -1, -1);
        repeat (3 * CLK_DIV) @(posedge clk);
        #1;
        send_frame(2, 9'h5A, 1'b0, 2'b11, -1, -1);
        check_status(2, "framing");
        pop_all(2);
        clear_errors(2);

        // Reset mid-data of 0xC3, released with the line still low, then 0x3C.
        send_frame(0, 9'hC3, 1'b0, 2'b11, -1, 5);
        rst_n = 1'b0;
        rxp[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (30) @(posedge clk);
        #1 rxp[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_status(i, "post_reset");
        send_frame(0, 9'h3C, 1'b0, 2'b11, -1, -1);
        check_status(0, "after_reset");
        pop_all(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
